// File: rtl/rgb_accum_sched.sv
// Per-channel R/G/B picture accumulator sharing one carry-skip adder; 4 cycles per pixel, sum_r/g/b land 1/2/3 cycles after accept.
// Backpressure: pix_ready only in IDLE; sums held in DONE until sum_ack; clear aborts from any state.
module rgb_cska #(
  parameter int W   = 22,
  parameter int BLK = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);
  always_comb begin : add
    logic c, blk_c, blk_p, p;
    s     = '0;
    c     = 1'b0;
    blk_c = 1'b0;
    blk_p = 1'b1;
    for (int i = 0; i < W; i++) begin
      p     = a[i] ^ b[i];
      s[i]  = p ^ c;
      c     = (a[i] & b[i]) | (p & c);
      blk_p = blk_p & p;
      // a fully propagating block forwards its incoming carry straight to the next block
      if ((i % BLK) == (BLK - 1) || i == W - 1) begin
        c     = blk_p ? blk_c : c;
        blk_c = c;
        blk_p = 1'b1;
      end
    end
  end
endmodule

module rgb_accum_sched #(
  parameter int CH_W    = 8,
  parameter int ACC_W   = 22,
  parameter int PIX_CNT = 16384,
  parameter int CNT_W   = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             pix_valid,
  input  logic [CH_W-1:0]  pix_r,
  input  logic [CH_W-1:0]  pix_g,
  input  logic [CH_W-1:0]  pix_b,
  output logic             pix_ready,
  output logic [ACC_W-1:0] sum_r,
  output logic [ACC_W-1:0] sum_g,
  output logic [ACC_W-1:0] sum_b,
  output logic             sum_valid,
  input  logic             sum_ack,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, ADD_R, ADD_G, ADD_B, DONE} state_t;

  state_t           state, state_nxt;
  logic [CH_W-1:0]  r_lat, g_lat, b_lat;
  logic [ACC_W-1:0] acc_r, acc_g, acc_b;
  logic [ACC_W-1:0] add_a, add_b, add_s;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             accept, last_pix, zero_all;

  assign accept   = (state == IDLE) && pix_valid && !clear;
  assign last_pix = (cnt == CNT_W'(PIX_CNT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    zero_all  = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      zero_all  = 1'b1;
    end else begin
      case (state)
        IDLE:    if (pix_valid) state_nxt = ADD_R;
        ADD_R:   state_nxt = ADD_G;
        ADD_G:   state_nxt = ADD_B;
        ADD_B:   state_nxt = last_pix ? DONE : IDLE;
        DONE: begin
          if (sum_ack) begin
            state_nxt = IDLE;
            zero_all  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    add_a = acc_r;
    add_b = {{(ACC_W - CH_W){1'b0}}, r_lat};
    case (state)
      ADD_G: begin
        add_a = acc_g;
        add_b = {{(ACC_W - CH_W){1'b0}}, g_lat};
      end
      ADD_B: begin
        add_a = acc_b;
        add_b = {{(ACC_W - CH_W){1'b0}}, b_lat};
      end
      default: ;
    endcase
  end

  rgb_cska #(.W(ACC_W), .BLK(4)) u_acc_add (.a(add_a), .b(add_b), .s(add_s));

  // wraps to zero on the last pixel; DONE is reached before that value matters
  rgb_cska #(.W(CNT_W), .BLK(4)) u_cnt_add (.a(cnt), .b(CNT_W'(1)), .s(cnt_inc));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
      acc_g <= '0;
      acc_b <= '0;
      cnt   <= '0;
      r_lat <= '0;
      g_lat <= '0;
      b_lat <= '0;
    end else if (zero_all) begin
      acc_r <= '0;
      acc_g <= '0;
      acc_b <= '0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        r_lat <= pix_r;
        g_lat <= pix_g;
        b_lat <= pix_b;
      end
      case (state)
        ADD_R: acc_r <= add_s;
        ADD_G: acc_g <= add_s;
        ADD_B: begin
          acc_b <= add_s;
          cnt   <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

  assign pix_ready = (state == IDLE);
  assign sum_valid = (state == DONE);
  assign busy      = (state == ADD_R) || (state == ADD_G) || (state == ADD_B);
  assign sum_r     = acc_r;
  assign sum_g     = acc_g;
  assign sum_b     = acc_b;
  assign pix_cnt   = cnt;
endmodule

// File: tb/tb_rgb_accum_sched.sv
// Scoreboard bench: small picture (4 pixels) instance for protocol checks, full-size instance for the 16384-pixel sum.
module tb_rgb_accum_sched;
  localparam int CH_W = 8, ACC_W = 22, PIX_CNT = 4, CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0, clear = 1'b0, pix_valid = 1'b0, sum_ack = 1'b0;
  logic [CH_W-1:0] pix_r = '0, pix_g = '0, pix_b = '0;
  logic pix_ready, sum_valid, busy;
  logic [ACC_W-1:0] sum_r, sum_g, sum_b;
  logic [CNT_W-1:0] pix_cnt;

  logic clear_f = 1'b0, pix_valid_f = 1'b0, sum_ack_f = 1'b0;
  logic [CH_W-1:0] pix_r_f = '0, pix_g_f = '0, pix_b_f = '0;
  logic pix_ready_f, sum_valid_f, busy_f;
  logic [ACC_W-1:0] sum_r_f, sum_g_f, sum_b_f;
  logic [13:0] pix_cnt_f;

  int n_chk = 0, n_err = 0;
  longint cyc = 0;
  logic sb_seen = 1'b0;

  typedef struct { int r; int g; int b; } sums_t;
  sums_t exp_q[$];

  rgb_accum_sched #(.CH_W(CH_W), .ACC_W(ACC_W), .PIX_CNT(PIX_CNT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .pix_valid(pix_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_ready(pix_ready),
    .sum_r(sum_r), .sum_g(sum_g), .sum_b(sum_b), .sum_valid(sum_valid),
    .sum_ack(sum_ack), .pix_cnt(pix_cnt), .busy(busy));

  rgb_accum_sched dut_full (
    .clk(clk), .rst(rst), .clear(clear_f), .pix_valid(pix_valid_f),
    .pix_r(pix_r_f), .pix_g(pix_g_f), .pix_b(pix_b_f), .pix_ready(pix_ready_f),
    .sum_r(sum_r_f), .sum_g(sum_g_f), .sum_b(sum_b_f), .sum_valid(sum_valid_f),
    .sum_ack(sum_ack_f), .pix_cnt(pix_cnt_f), .busy(busy_f));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns one cycle after the accepting edge, pix_valid left high
  task automatic drive_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int guard = 0;
    pix_valid = 1'b1;
    pix_r = r; pix_g = g; pix_b = b;
    while (!pix_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("accept_wait", guard < 20, 1);
    tick();
  endtask

  task automatic wait_done(input int max_cyc);
    int guard = 0;
    while (!sum_valid && guard < max_cyc) begin
      tick();
      guard++;
    end
    check("done_wait", sum_valid, 1);
  endtask

  // small-instance scoreboard: one expected picture popped per DONE entry
  initial begin
    sums_t e;
    forever begin
      tick();
      if (sum_valid && !sb_seen) begin
        check("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_sum_r", sum_r, e.r);
          check("sb_sum_g", sum_g, e.g);
          check("sb_sum_b", sum_b, e.b);
        end
      end
      sb_seen = sum_valid;
    end
  end

  initial begin
    longint t0;
    int guard;
    #1 rst = 1'b1;
    tick(); tick();
    check("rst_ready", pix_ready, 1);
    check("rst_valid", sum_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", {10'd0, sum_r} | sum_g | sum_b, 0);
    check("rst_cnt", pix_cnt, 0);
    rst = 1'b0;
    tick();

    // single pixel latency
    drive_pix(8'd10, 8'd20, 8'd30);
    pix_valid = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_r_pre", sum_r, 0);
    tick();
    check("t1_r", sum_r, 10);
    check("t1_g_pre", sum_g, 0);
    tick();
    check("t1_g", sum_g, 20);
    check("t1_b_pre", sum_b, 0);
    tick();
    check("t1_b", sum_b, 30);
    check("t1_cnt", pix_cnt, 1);
    check("t1_idle", pix_ready, 1);
    check("t1_not_busy", busy, 0);

    sum_ack = 1'b1;
    tick();
    sum_ack = 1'b0;
    check("ack_idle_r", sum_r, 10);
    check("ack_idle_cnt", pix_cnt, 1);

    clear = 1'b1; pix_valid = 1'b1; pix_r = 8'd1; pix_g = 8'd1; pix_b = 8'd1;
    tick();
    clear = 1'b0; pix_valid = 1'b0;
    check("clr_idle_busy", busy, 0);
    check("clr_idle_r", sum_r, 0);
    check("clr_idle_b", sum_b, 0);
    check("clr_idle_cnt", pix_cnt, 0);

    // four saturated pixels back to back; cycle 1 is the one where pix_valid is first presented
    exp_q.push_back('{1020, 1020, 1020});
    t0 = cyc;
    for (int i = 0; i < 4; i++) drive_pix(8'd255, 8'd255, 8'd255);
    wait_done(20);
    check("t2_latency", 32'(cyc - t0), 16);
    check("t2_ready", pix_ready, 0);

    // DONE holds with pix_valid still high
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_r", sum_r, 1020);
      check("t3_b", sum_b, 1020);
      check("t3_valid", sum_valid, 1);
      check("t3_ready", pix_ready, 0);
    end
    pix_valid = 1'b0;
    sum_ack = 1'b1;
    tick();
    sum_ack = 1'b0;
    check("t3_ack_r", sum_r, 0);
    check("t3_ack_g", sum_g, 0);
    check("t3_ack_b", sum_b, 0);
    check("t3_ack_cnt", pix_cnt, 0);
    check("t3_ack_ready", pix_ready, 1);
    check("t3_ack_valid", sum_valid, 0);

    // clear during ADD_G of the second pixel
    drive_pix(8'd5, 8'd6, 8'd7);
    pix_valid = 1'b0;
    tick(); tick(); tick();
    check("t4_cnt1", pix_cnt, 1);
    drive_pix(8'd100, 8'd110, 8'd120);
    pix_valid = 1'b0;
    tick();
    check("t4_r_partial", sum_r, 105);
    check("t4_in_add", busy, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4_ready", pix_ready, 1);
    check("t4_busy", busy, 0);
    check("t4_r", sum_r, 0);
    check("t4_g", sum_g, 0);
    check("t4_b", sum_b, 0);
    check("t4_cnt", pix_cnt, 0);
    tick();
    check("t4_g_after", sum_g, 0);

    exp_q.push_back('{262, 15, 146});
    drive_pix(8'd1, 8'd2, 8'd3);
    drive_pix(8'd4, 8'd5, 8'd6);
    drive_pix(8'd7, 8'd8, 8'd9);
    drive_pix(8'd250, 8'd0, 8'd128);
    pix_valid = 1'b0;
    wait_done(20);
    tick();
    sum_ack = 1'b1;
    tick();
    sum_ack = 1'b0;

    // async reset between edges while in ADD_B
    drive_pix(8'd9, 8'd9, 8'd9);
    pix_valid = 1'b0;
    tick(); tick();
    check("t5_busy_pre", busy, 1);
    check("t5_g_pre", sum_g, 9);
    #2 rst = 1'b1;
    #1;
    check("t5_r", sum_r, 0);
    check("t5_g", sum_g, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", pix_ready, 1);
    check("t5_valid", sum_valid, 0);
    tick();
    rst = 1'b0;
    tick();

    // full-size picture on the default-parameter instance
    pix_valid_f = 1'b1; pix_r_f = 8'd255; pix_g_f = 8'd0; pix_b_f = 8'd1;
    guard = 0;
    while (!sum_valid_f && guard < 70000) begin
      tick();
      guard++;
    end
    pix_valid_f = 1'b0;
    check("t6_done", sum_valid_f, 1);
    check("t6_r", sum_r_f, 4177920);
    check("t6_g", sum_g_f, 0);
    check("t6_b", sum_b_f, 16384);
    check("t6_ready", pix_ready_f, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
